msk_tx_mod: RTL

Transmit-side MSK modulator producing oversampled complex baseband I/Q at OSF samples per symbol. It is the source-end counterpart of the receive timing-recovery chain and feeds the I/Q stream consumed by the Gardner TED / interpolator path. Bits are accepted through a valid/ready handshake into a small FIFO. Each symbol advances a continuous-phase accumulator by ±π/2, linearly over OSF samples. A symbol-boundary strobe accompanies the first sample of every symbol.

---
 rtl/msk_tx_mod.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/msk_tx_mod.sv
// MSK transmit modulator: a small bit FIFO feeds a continuous-phase accumulator
// that steps +/-1 per sample through an M = 4*OSF entry cos/sin table.
module msk_tx_mod #(
    parameter int unsigned OSF        = 20,
    parameter int unsigned WIQ        = 16,
    parameter int unsigned AMP        = 16384,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_i,
    input  logic                  bit_i,
    input  logic                  bit_valid_i,
    output logic                  bit_ready_o,
    output logic signed [WIQ-1:0] i_out_o,
    output logic signed [WIQ-1:0] q_out_o,
    output logic                  iq_val_o,
    output logic                  sym_valid_o,
    output logic                  underflow_o
);

    localparam int unsigned M          = 4 * OSF;
    localparam int unsigned P_W        = $clog2(M);
    localparam int unsigned C_W        = $clog2(OSF);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = AW + 1;
    localparam int unsigned FRAC       = 30;
    localparam longint      FX_ONE     = 64'sd1 << FRAC;
    localparam longint      PI_HALF_FX = 64'sd1686629713;

    typedef logic [M-1:0][WIQ-1:0] lut_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    // Scale a Q30 value in [0,1] by AMP and round half up.
    function automatic longint amp_round(input longint v);
        return (longint'(AMP) * v + (FX_ONE >>> 1)) >>> FRAC;
    endfunction

    // Integer Taylor series over one quadrant, mirrored into the other three.
    function automatic lut_t build_lut(input logic want_q);
        lut_t        lut;
        longint      theta, x2, c, s, tc, ts, ci, si, iv, qv;
        int unsigned quad, r;
        lut = '0;
        for (int unsigned p = 0; p < M; p++) begin
            quad  = p / OSF;
            r     = p % OSF;
            theta = (PI_HALF_FX * longint'(r) + longint'(OSF / 2)) / longint'(OSF);
            x2    = (theta * theta) >>> FRAC;
            c     = FX_ONE;
            tc    = FX_ONE;
            s     = theta;
            ts    = theta;
            for (int k = 1; k <= 10; k++) begin
                tc = -((tc * x2) >>> FRAC) / longint'((2 * k - 1) * (2 * k));
                ts = -((ts * x2) >>> FRAC) / longint'((2 * k) * (2 * k + 1));
                c  = c + tc;
                s  = s + ts;
            end
            ci = amp_round(c);
            si = amp_round(s);
            case (quad)
                0:       begin iv = ci;  qv = si;  end
                1:       begin iv = -si; qv = ci;  end
                2:       begin iv = -ci; qv = -si; end
                default: begin iv = si;  qv = -ci; end
            endcase
            lut[P_W'(p)] = want_q ? WIQ'(qv) : WIQ'(iv);
        end
        return lut;
    endfunction

    localparam lut_t I_LUT = build_lut(1'b0);
    localparam lut_t Q_LUT = build_lut(1'b1);

    state_e                  state_q, state_d;
    logic [P_W-1:0]          p_q, p_d;
    logic [C_W-1:0]          cnt_q, cnt_d;
    logic                    dir_q, dir_d;
    logic [FIFO_DEPTH-1:0]   mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    rdy_q, rdy_d;
    logic signed [WIQ-1:0]   i_q, i_d;
    logic signed [WIQ-1:0]   q_q, q_d;
    logic                    iq_val_q, iq_val_d;
    logic                    sym_q, sym_d;
    logic                    unf_q, unf_d;

    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    step;
    logic                    sym_start;
    logic                    dir_now;

    // Sample step, FIFO bookkeeping and registered-output next values.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        i_d      = i_q;
        q_d      = q_q;

        fifo_empty = (count_q == '0);
        push       = bit_valid_i && rdy_q;
        step       = en_i && ((state_q == S_RUN) || !fifo_empty);
        sym_start  = (cnt_q == '0);
        pop        = step && sym_start && !fifo_empty;

        dir_now = dir_q;
        if (step && sym_start) begin
            dir_now = fifo_empty ? 1'b0 : mem_q[rd_ptr_q];
        end

        iq_val_d = step;
        sym_d    = step && sym_start;
        unf_d    = step && sym_start && fifo_empty;

        if (step) begin
            state_d = S_RUN;
            i_d     = I_LUT[p_q];
            q_d     = Q_LUT[p_q];
            dir_d   = dir_now;
            if (dir_now) begin
                p_d = (p_q == P_W'(M - 1)) ? '0 : p_q + P_W'(1);
            end else begin
                p_d = (p_q == '0) ? P_W'(M - 1) : p_q - P_W'(1);
            end
            cnt_d = (cnt_q == C_W'(OSF - 1)) ? '0 : cnt_q + C_W'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = bit_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Ready is a flop of the next count, so it never sees the pop combinationally.
        rdy_d = (count_d < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
            i_q      <= '0;
            q_q      <= '0;
            iq_val_q <= 1'b0;
            sym_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            i_q      <= i_d;
            q_q      <= q_d;
            iq_val_q <= iq_val_d;
            sym_q    <= sym_d;
            unf_q    <= unf_d;
        end
    end

    assign bit_ready_o = rdy_q;
    assign i_out_o     = i_q;
    assign q_out_o     = q_q;
    assign iq_val_o    = iq_val_q;
    assign sym_valid_o = sym_q;
    assign underflow_o = unf_q;

endmodule
